pipe_field_engine: RTL
======================

# pipe_field_engine

Parametrised obstacle field and renderer for the side-scrolling bird game. It holds a column array of pipe gap heights and spawns new pipes from an LFSR. It also checks the bird against the leading column and streams one pixel per cycle to the 160x120 VGA adapter. It sits between the game control FSM, which provides `start`, `step` and the bird height, and the adapter's `x/y/colour/plot` inputs, and it reports `collide` and `passed` back for scoring.

## Interface
- NUM_COLS, 40, obstacle columns on screen; NUM_COLS*COL_W <= 160
- COL_W, 4, pixel width of one column
- FIELD_H, 80, field height in rows (row 0 = ground)
- Y_BASE, 84, screen y of row 0; y = Y_BASE - row
- GAP, 24, vertical opening of a pipe in rows
- MIN_Y, 8, lowest gap bottom
- SPACING, 8, columns between spawned pipes
- BIRD_H, 4, bird height in rows
- LFSR_SEED, 16'hACE1, LFSR reset value (nonzero)
- clk, in, 1, system clock (50 MHz)
- resetn, in, 1, reset, synchronous, active-low
- start, in, 1, pulse: clear field, arm game, restart scan
- step, in, 1, pulse: request one-column scroll
- bird_h, in, 7, bird bottom row
- x, out, 8, pixel x
- y, out, 7, pixel y
- colour, out, 3, pixel colour
- plot, out, 1, pixel valid
- frame_done, out, 1, one-cycle pulse after the last pixel of a frame
- collide, out, 1, sticky collision flag
- passed, out, 1, one-cycle pulse when a pipe leaves column 0

## Operation
- Column array col[0..NUM_COLS-1], 7 bits each. 0 = no pipe. Otherwise the value is the gap bottom; the gap covers rows col[c] .. col[c]+GAP-1.
- `run` flag: cleared by reset. Set by `start`. Cleared when `collide` sets.
- Step handling:
  - `step` with run=1 sets `pending`. A second `step` in the same frame coalesces into it.
  - `step` with run=0 is ignored.
  - `pending` is applied only at the frame boundary (cycle of frame_done), then cleared.
- Shift: col[i] <= col[i+1]. The new col[NUM_COLS-1] is chosen by the spawn counter:
  - spawn counter == SPACING-1: new column = MIN_Y + (lfsr[15:0] mod (FIELD_H-GAP-2*MIN_Y+1)). Defaults give the range 8..48. Counter wraps to 0.
  - otherwise: new column = 0 and the counter increments.
  - The LFSR advances once per applied shift: 16-bit Galois, taps 16'hB400.
- passed: pulses the cycle after a shift whose outgoing col[0] was nonzero.
- Collision is evaluated every cycle while run=1. Any of these sets `collide`:
  - bird_h == 0
  - bird_h + BIRD_H > FIELD_H
  - col[0] != 0 and bird_h < col[0]
  - col[0] != 0 and bird_h + BIRD_H > col[0] + GAP
- `collide` is cleared only by reset or `start`.
- start: clears col[], pending, spawn counter, collide and passed, and sets run=1. The LFSR is not reseeded. The scan restarts at pixel 0 the next cycle.
- start and step in the same cycle: start wins, the step is dropped.
- Scan FSM:
  - SCAN iterates c (0..NUM_COLS-1), then px (0..COL_W-1), then row (0..FIELD_H-1), with row fastest.
  - x = c*COL_W + px; y = Y_BASE - row.
  - Colour priority:
    - bird (3'b100): c==0, px<2, bird_h <= row < bird_h+BIRD_H
    - pipe (3'b010): col[c]!=0 and row outside the gap
    - background (3'b011): all other pixels
  - After the last pixel the FSM enters BOUNDARY for 1 cycle (frame_done, apply pending), then returns to SCAN at pixel 0.
  - The scan runs continuously regardless of run.

## Timing
- Reset values: x=0, y=0, colour=0, plot=0, frame_done=0, collide=0, passed=0, run=0, pending=0, col[]=0, spawn=0, lfsr=LFSR_SEED, FSM=SCAN at pixel 0.
- Pixel outputs are registered, with a 1-cycle latency from the scan counters. The first pixel (x=0, y=Y_BASE) has plot=1 on the 2nd cycle after resetn rises.
- Frame period = NUM_COLS*COL_W*FIELD_H + 1 cycles (12801 with defaults). plot=0 only in the BOUNDARY output cycle.
- The column array never changes mid-frame, so there is no tearing.
- collide is registered 1 cycle after the condition.
- passed is 1 cycle after the boundary.
- Reset mid-frame aborts the scan immediately.

## Test plan
- Reset, then release → x=0/y=84/plot=1 on cycle 2; frame_done exactly every 12801 cycles; all col[]=0 and the whole frame is background colour 3'b011 except the bird pixels.
- start, then 8 steps, one per frame → after the 8th boundary col[39] is in 8..48 and matches the reference LFSR model; 39 frames later col[0] equals that value; one more step → passed pulses once.
- Two steps in one frame → exactly one shift at the boundary; a step with run=0 → no shift.
- col[0]=20: bird_h=25 → no collide. bird_h=10 → collide=1 after 1 cycle, run=0, later steps ignored, collide held until start.
- bird_h=0 with an empty field → collide; bird_h=77 (77+4>80) → collide.
- start and step in the same cycle → field cleared, no shift. resetn low mid-frame → all reset values next cycle.

Source files
------------

// File: rtl/pipe_field_engine.sv
// Obstacle field for the side-scrolling bird game: pipe column array with LFSR spawning,
// bird collision against the leading column, and a one-pixel-per-cycle VGA frame scan.
module pipe_field_engine #(
    parameter int          NUM_COLS  = 40,
    parameter int          COL_W     = 4,
    parameter int          FIELD_H   = 80,
    parameter int          Y_BASE    = 84,
    parameter int          GAP       = 24,
    parameter int          MIN_Y     = 8,
    parameter int          SPACING   = 8,
    parameter int          BIRD_H    = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       step,
    input  logic [6:0] bird_h,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       frame_done,
    output logic       collide,
    output logic       passed
);

    localparam int C_W  = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int PX_W = (COL_W > 1) ? $clog2(COL_W) : 1;
    localparam int SPAN = FIELD_H - GAP - 2 * MIN_Y + 1;

    typedef enum logic {SCAN, BOUNDARY} state_t;

    state_t          state, state_next;
    logic [C_W-1:0]  c_p0;
    logic [PX_W-1:0] px_p0;
    logic [6:0]      row_p0;
    logic            last_pix, vld_p0, bnd_p0;
    logic [7:0]      x_p0;
    logic [6:0]      y_p0;
    logic [2:0]      colour_p0;

    logic [6:0]  col [NUM_COLS];
    logic [7:0]  spawn_cnt;
    logic [15:0] lfsr;
    logic        run, pending, shift, spawn_hit, hit;
    int          ci, pi, ri, bh, gap_lo, c0;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [6:0] spawn_gap(input logic [15:0] s);
        return 7'(MIN_Y + int'(s) % SPAN);
    endfunction

    // Scan stage p0: frame counters, row fastest, then pixel-in-column, then column
    always_ff @(posedge clk) begin
        if (!resetn || start) begin
            state <= SCAN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            SCAN:     if (last_pix) state_next = BOUNDARY;
            BOUNDARY: state_next = SCAN;
            default:  state_next = SCAN;
        endcase
    end

    always_comb begin
        vld_p0 = (state == SCAN);
        bnd_p0 = (state == BOUNDARY);
    end

    assign last_pix = (int'(c_p0) == NUM_COLS - 1) && (int'(px_p0) == COL_W - 1) &&
                      (int'(row_p0) == FIELD_H - 1);

    always_ff @(posedge clk) begin
        if (!resetn || start) begin
            c_p0   <= '0;
            px_p0  <= '0;
            row_p0 <= '0;
        end else if (state == SCAN) begin
            if (int'(row_p0) == FIELD_H - 1) begin
                row_p0 <= '0;
                if (int'(px_p0) == COL_W - 1) begin
                    px_p0 <= '0;
                    c_p0  <= (int'(c_p0) == NUM_COLS - 1) ? '0 : c_p0 + C_W'(1);
                end else begin
                    px_p0 <= px_p0 + PX_W'(1);
                end
            end else begin
                row_p0 <= row_p0 + 7'd1;
            end
        end
    end

    always_comb begin
        ci        = int'(c_p0);
        pi        = int'(px_p0);
        ri        = int'(row_p0);
        gap_lo    = int'(col[c_p0]);
        x_p0      = 8'(ci * COL_W + pi);
        y_p0      = 7'(Y_BASE - ri);
        colour_p0 = 3'b011;
        if (ci == 0 && pi < 2 && ri >= bh && ri < bh + BIRD_H) begin
            colour_p0 = 3'b100;
        end else if (gap_lo != 0 && (ri < gap_lo || ri >= gap_lo + GAP)) begin
            colour_p0 = 3'b010;
        end
    end

    // Output stage p1: registered pixel, held during the boundary cycle
    always_ff @(posedge clk) begin
        if (!resetn) begin
            x          <= '0;
            y          <= '0;
            colour     <= '0;
            plot       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            plot       <= vld_p0;
            frame_done <= bnd_p0;
            if (vld_p0) begin
                x      <= x_p0;
                y      <= y_p0;
                colour <= colour_p0;
            end
        end
    end

    // The field only moves on the boundary cycle, so a frame never tears
    assign shift     = bnd_p0 && pending && !start;
    assign spawn_hit = (int'(spawn_cnt) == SPACING - 1);

    always_comb begin
        bh  = int'(bird_h);
        c0  = int'(col[0]);
        hit = run && (bh == 0 || bh + BIRD_H > FIELD_H ||
                      (c0 != 0 && (bh < c0 || bh + BIRD_H > c0 + GAP)));
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            run <= 1'b0;
        end else if (start) begin
            run <= 1'b1;
        end else if (hit) begin
            run <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || start) begin
            pending   <= 1'b0;
            collide   <= 1'b0;
            passed    <= 1'b0;
            spawn_cnt <= '0;
        end else begin
            pending <= (pending && !shift) || (step && run);
            collide <= collide || hit;
            passed  <= shift && (col[0] != '0);
            if (shift) spawn_cnt <= spawn_hit ? '0 : spawn_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || start) begin
            for (int i = 0; i < NUM_COLS; i++) col[i] <= '0;
        end else if (shift) begin
            for (int i = 0; i < NUM_COLS - 1; i++) col[i] <= col[i+1];
            col[NUM_COLS-1] <= spawn_hit ? spawn_gap(lfsr) : '0;
        end
    end

    // The seed is kept across start so successive games see different fields
    always_ff @(posedge clk) begin
        if (!resetn) begin
            lfsr <= LFSR_SEED;
        end else if (shift) begin
            lfsr <= lfsr_step(lfsr);
        end
    end

endmodule
